// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared types and widths for the PC fetch sequencer.
package pc_pkg;
    localparam int PC_W   = 12;
    localparam int KEY_W  = 5;
    localparam int PROG_W = 2;

    localparam logic [PROG_W-1:0] PROG_NONE = 2'b00;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } pc_state_e;
endpackage

// File: rtl/pc_fetch_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);
    always_ff @(posedge clk) begin
        if (reset || clr)
            cnt <= '0;
        else if (inc && (cnt != '1))
            cnt <= cnt + CNT_W'(1);
    end
endmodule

// File: rtl/pc_fetch_ctrl.sv
// Program-counter sequencer driving branch_lut lookups on taken branches.
// Define PC_PERF_CNT_EN to enable the RUN-cycle and branch performance counters.
module pc_fetch_ctrl #(
    parameter int PC_W   = pc_pkg::PC_W,
    parameter int KEY_W  = pc_pkg::KEY_W,
    parameter int PROG_W = pc_pkg::PROG_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [PROG_W-1:0] prog_sel,
    input  logic              branch,
    input  logic [KEY_W-1:0]  branch_key,
    input  logic              halt,
    input  logic [PC_W-1:0]   lut_pos,
    output logic              lut_en,
    output logic [PROG_W-1:0] lut_prog,
    output logic [KEY_W-1:0]  lut_key,
    output logic [PC_W-1:0]   pc,
    output logic              running,
    output logic              done,
    output logic              overflow,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic [CNT_W-1:0]  branch_cnt
);
    import pc_pkg::*;

    pc_state_e         state, state_n;
    logic [PC_W-1:0]   pc_n;
    logic [PROG_W-1:0] prog_n;
    logic              ovf_n;
    logic              accept;

    // A start is only honoured outside RUN and with a real program number.
    assign accept = start && (prog_sel != PROG_NONE) && (state != RUN);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            pc       <= '0;
            lut_prog <= '0;
            overflow <= 1'b0;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            lut_prog <= prog_n;
            overflow <= ovf_n;
        end
    end

    always_comb begin
        state_n = state;
        pc_n    = pc;
        prog_n  = lut_prog;
        ovf_n   = overflow;
        case (state)
            IDLE, DONE: begin
                if (accept) begin
                    state_n = RUN;
                    pc_n    = '0;
                    prog_n  = prog_sel;
                    ovf_n   = 1'b0;
                end
            end
            RUN: begin
                if (halt) begin
                    state_n = DONE;
                end else if (branch) begin
                    pc_n = lut_pos;
                end else if (pc == '1) begin
                    // Fell off the end of the address space without a DONE.
                    ovf_n   = 1'b1;
                    state_n = DONE;
                end else begin
                    pc_n = pc + PC_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign lut_en  = (state == RUN) && branch && !halt;
    assign lut_key = lut_en ? branch_key : '0;
    assign running = (state == RUN);
    assign done    = (state == DONE);

`ifdef PC_PERF_CNT_EN
    sat_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (accept),
        .inc   (running),
        .cnt   (cycle_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_branch_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (accept),
        .inc   (lut_en),
        .cnt   (branch_cnt)
    );
`else
    assign cycle_cnt  = '0;
    assign branch_cnt = '0;
`endif
endmodule
